output_port_uart_tx: RTL and testbench

Consumer on the far side of the processor's 16-bit output register. Each strobed output word is captured into a small FIFO. The word is then serialized off-chip as two 8N1 UART bytes, low byte first. Sits between the top-level `out` bus / output-write strobe and a board-level TX pin.

---
 rtl/output_port_uart_tx.sv | 227 ++++++++++++++++++++++
 tb/tb_output_port_uart_tx.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_port_uart_tx.sv
// Word-wide capture FIFO feeding the output-port UART; count/full/empty come straight from flops.
// Latency: a pushed word is at the head one cycle after its push edge.
// Backpressure: a push while full is ignored; the caller sees full and accounts for the drop.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   push_vld,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop_rdy,
    output logic [WIDTH-1:0]       head_dat,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    // Occupancy is tracked by a count, so wrapped pointers never alias empty and full.
    assign full     = (count_q == (PTR_W+1)'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign head_dat = mem_q[rd_ptr_q];

    always_comb begin
        push_ok  = push_vld && !full;
        pop_ok   = pop_rdy && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end
endmodule

// Serializes each captured 16-bit output word as two 8N1 bytes, low byte first.
// Latency: word written into an empty, idle port drives the start bit one cycle later.
// Backpressure: none upstream; writes to a full FIFO are dropped and flagged in overflow.
module output_port_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        wr_en,
    input  logic [15:0]                 wr_data,
    input  logic                        ovf_clr,
    output logic                        tx,
    output logic                        busy,
    output logic                        full,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overflow
);
    localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic              byte_sel_q, byte_sel_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        hi_q, hi_d;
    logic              tx_q, tx_d;
    logic              ovf_q, ovf_d;
    logic              pop;
    logic              fifo_empty;
    logic [15:0]       head_dat;

    sync_fifo #(
        .WIDTH (16),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .push_vld (wr_en),
        .push_dat (wr_data),
        .pop_rdy  (pop),
        .head_dat (head_dat),
        .count    (fifo_count),
        .full     (full),
        .empty    (fifo_empty)
    );

    assign tx       = tx_q;
    assign overflow = ovf_q;
    assign busy     = (state_q != IDLE) || !fifo_empty;

    // A drop uses full as seen before the edge, so it beats both a same-cycle pop and ovf_clr.
    always_comb begin
        ovf_d = ovf_q;
        if (wr_en && full) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // tx_d carries the line level of the state being entered, keeping tx a pure flop output.
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        byte_sel_d = byte_sel_q;
        shift_d    = shift_q;
        hi_d       = hi_q;
        tx_d       = tx_q;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shift_d    = head_dat[7:0];
                    hi_d       = head_dat[15:8];
                    byte_sel_d = 1'b0;
                    baud_d     = '0;
                    state_d    = START;
                    tx_d       = 1'b0;
                end
            end
            START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 1'b1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (!byte_sel_q) begin
                        byte_sel_d = 1'b1;
                        shift_d    = hi_q;
                        state_d    = START;
                        tx_d       = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            byte_sel_q <= 1'b0;
            shift_q    <= '0;
            hi_q       <= '0;
            tx_q       <= 1'b1;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            byte_sel_q <= byte_sel_d;
            shift_q    <= shift_d;
            hi_q       <= hi_d;
            tx_q       <= tx_d;
            ovf_q      <= ovf_d;
        end
    end
endmodule

// File: tb/tb_output_port_uart_tx.sv
// Bench for output_port_uart_tx: vector table, hand-written frame sequences, random traffic vs a frame-position model.
`timescale 1ns/1ps
module tb_output_port_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int FRAME = 20 * CPB;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [15:0]   wr_data = '0;
    logic          ovf_clr = 1'b0;
    logic          tx, busy, full, overflow;
    logic [CW-1:0] fifo_count;

    int errors = 0;
    int checks = 0;

    output_port_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .ovf_clr    (ovf_clr),
        .tx         (tx),
        .busy       (busy),
        .full       (full),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clock = ~clock;

    // Reference: a word queue plus the cycle position inside the 20-bit-period frame in flight.
    logic [15:0] m_q[$];
    bit          m_active = 1'b0;
    int          m_pos = 0;
    logic [15:0] m_cur = '0;
    bit          m_ovf = 1'b0;

    function automatic logic exp_bit(input logic [15:0] w, input int pos);
        int b;
        int k;
        b = pos / CPB;
        k = b % 10;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return w[(b / 10) * 8 + k - 1];
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_active = 1'b0;
        m_pos    = 0;
        m_ovf    = 1'b0;
    endtask

    task automatic model_edge(input logic we, input logic [15:0] d, input logic clr);
        bit was_full;
        was_full = (m_q.size() == DEPTH);
        if (!m_active && m_q.size() != 0) begin
            m_cur    = m_q.pop_front();
            m_active = 1'b1;
            m_pos    = 0;
        end else if (m_active) begin
            m_pos++;
            if (m_pos == FRAME) m_active = 1'b0;
        end
        if (we && !was_full) m_q.push_back(d);
        if (we && was_full) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_model(input string name);
        logic [CW+3:0] exp_v;
        logic [CW+3:0] got_v;
        exp_v = {(m_active ? exp_bit(m_cur, m_pos) : 1'b1), (m_active || m_q.size() != 0),
                 (m_q.size() == DEPTH), CW'(m_q.size()), m_ovf};
        got_v = {tx, busy, full, fifo_count, overflow};
        checks++;
        if (got_v !== exp_v) begin
            errors++;
            $display("FAIL %s @%0t: {tx,busy,full,count,ovf} got %b expected %b", name, $time, got_v, exp_v);
        end
    endtask

    task automatic step(input string name, input logic we, input logic [15:0] d, input logic clr);
        wr_en   = we;
        wr_data = d;
        ovf_clr = clr;
        @(posedge clock);
        model_edge(we, d, clr);
        #1;
        check_model(name);
    endtask

    // Independent line receiver: mid-bit sampling, bytes collected in arrival order.
    int         rx_cnt = -1;
    logic [7:0] rx_byte = '0;
    logic [7:0] rx_bytes[$];

    always @(negedge clock) begin
        if (!reset_n) begin
            rx_cnt = -1;
        end else if (rx_cnt < 0) begin
            if (tx === 1'b0) rx_cnt = 0;
        end else begin
            rx_cnt++;
            if (rx_cnt % CPB == CPB / 2 && rx_cnt / CPB >= 1 && rx_cnt / CPB <= 8) begin
                rx_byte[rx_cnt / CPB - 1] = tx;
            end else if (rx_cnt == 9 * CPB + CPB / 2) begin
                checks++;
                if (tx !== 1'b1) begin
                    errors++;
                    $display("FAIL rx_stop: got %b expected 1", tx);
                end
                rx_bytes.push_back(rx_byte);
                rx_cnt = -1;
            end
        end
    end

    typedef struct {
        logic          we;
        logic [15:0]   d;
        logic          clr;
        logic [CW-1:0] cnt;
        logic          fl;
        logic          ov;
        logic          bz;
    } vec_t;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tbl[9];
        logic [19:0] pat2;
        logic [15:0] e;
        int          n;
        int          lows;
        logic        t80;
        logic        t81;

        tbl[0] = '{1'b1, 16'h1111, 1'b0, CW'(1), 1'b0, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 16'h2222, 1'b0, CW'(1), 1'b0, 1'b0, 1'b1};
        tbl[2] = '{1'b1, 16'h3333, 1'b0, CW'(2), 1'b0, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 16'h4444, 1'b0, CW'(3), 1'b0, 1'b0, 1'b1};
        tbl[4] = '{1'b1, 16'h5555, 1'b0, CW'(4), 1'b1, 1'b0, 1'b1};
        tbl[5] = '{1'b1, 16'h6666, 1'b0, CW'(4), 1'b1, 1'b1, 1'b1};
        tbl[6] = '{1'b1, 16'h7777, 1'b1, CW'(4), 1'b1, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 16'h8888, 1'b1, CW'(4), 1'b1, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 16'h9999, 1'b0, CW'(4), 1'b1, 1'b0, 1'b1};
        // 0xA55A on the line, bit period i at pat2[i]: start, 5A lsb-first, stop, start, A5, stop.
        pat2 = 20'hD2AB4;

        // Reset held while inputs toggle randomly.
        model_reset();
        for (int i = 0; i < 20; i++) begin
            wr_en   = 1'($urandom);
            wr_data = 16'($urandom);
            ovf_clr = 1'($urandom);
            @(posedge clock);
            #1;
            check("reset_state", {tx, busy, full, fifo_count, overflow}, {1'b1, 1'b0, 1'b0, CW'(0), 1'b0});
        end
        wr_en   = 1'b0;
        ovf_clr = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            step("idle_after_reset", 1'b0, 16'($urandom), 1'b0);
            if (tx !== 1'b1) lows++;
        end
        check("idle_tx_lows", lows, 0);

        // Fill, overflow, clear-vs-set priority.
        rx_bytes.delete();
        for (int i = 0; i < 9; i++) begin
            step("tbl_model", tbl[i].we, tbl[i].d, tbl[i].clr);
            check($sformatf("tbl[%0d] {cnt,full,ovf,busy}", i), {fifo_count, full, overflow, busy},
                  {tbl[i].cnt, tbl[i].fl, tbl[i].ov, tbl[i].bz});
        end
        n = 0;
        while (busy && n < 8 * FRAME) begin
            step("drain", 1'b0, 16'($urandom), 1'b0);
            n++;
        end
        check("drain_busy", busy, 0);
        check("rx_byte_count", rx_bytes.size(), 10);
        for (int i = 0; i < 5 && 2 * i + 1 < rx_bytes.size(); i++) begin
            e = 16'(16'h1111 * (i + 1));
            check($sformatf("rx_word[%0d]", i), {rx_bytes[2*i+1], rx_bytes[2*i]}, e);
        end

        // Single word 0xA55A: exact line waveform.
        step("a55a_capture", 1'b1, 16'hA55A, 1'b0);
        check("a55a_tx_at_capture", tx, 1);
        for (int k = 0; k < FRAME; k++) begin
            step("a55a_model", 1'b0, 16'($urandom), 1'b0);
            check($sformatf("a55a_tx[%0d]", k), tx, pat2[k / CPB]);
        end
        step("a55a_after", 1'b0, 16'h0, 1'b0);
        check("a55a_busy_after", busy, 0);

        // Two queued words: total duration and one idle cycle between them.
        step("pair_w0", 1'b1, 16'h0001, 1'b0);
        step("pair_w1", 1'b1, 16'h8000, 1'b0);
        check("pair_first_start", tx, 0);
        n   = 0;
        t80 = 1'bx;
        t81 = 1'bx;
        while (busy && n < 400) begin
            step("pair_model", 1'b0, 16'($urandom), 1'b0);
            n++;
            if (n == 80) t80 = tx;
            if (n == 81) t81 = tx;
        end
        check("pair_duration", n, 2 * FRAME + 1);
        check("pair_gap_high", t80, 1);
        check("pair_second_start", t81, 0);

        // Asynchronous reset in the middle of the high byte's data bits.
        step("mid_w0", 1'b1, 16'h00FF, 1'b0);
        step("mid_w1", 1'b1, 16'h1234, 1'b0);
        for (int k = 0; k < 50; k++) step("mid_model", 1'b0, 16'($urandom), 1'b0);
        check("mid_tx_before_reset", tx, 0);
        check("mid_count_before_reset", fifo_count, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs", {tx, busy, full, fifo_count, overflow}, {1'b1, 1'b0, 1'b0, CW'(0), 1'b0});
        model_reset();
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            step("post_reset_idle", 1'b0, 16'($urandom), 1'b0);
            if (tx !== 1'b1) lows++;
        end
        check("post_reset_no_start", lows, 0);

        // Random traffic with bursts against the reference model.
        for (int i = 0; i < 3000; i++) begin
            logic we;
            we = ($urandom_range(0, 29) == 0) || ((i % 700) > 690);
            step("random", we, 16'($urandom), $urandom_range(0, 49) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
